dvi_timing_ctrl: RTL and testbench

Video timing controller that sequences the DVI generator. It runs horizontal and vertical pixel counters, decodes them into display-enable and sync strobes, and provides pixel coordinates plus line and frame pulses to the pixel source. It sits in the pixel clock domain. Its outputs drive the generator's display-enable input and its channel-0 control pair directly. A start/stop handshake means video only begins and ends on frame boundaries.

---
 rtl/dvi_timing_ctrl.sv | 132 +++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_ctrl.sv
// Video timing controller for the DVI generator: pixel counters, DE/sync decode,
// coordinates and line/frame strobes, with start/stop aligned to frame boundaries.
module dvi_timing_ctrl #(
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0,
    parameter int CW     = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic          o_busy,
    output logic          o_de,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic [1:0]    o_ctrl_ch0,
    output logic [CW-1:0] o_sx,
    output logic [CW-1:0] o_sy,
    output logic          o_line,
    output logic          o_frame
);
    localparam int H_TOTAL  = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_RES + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_RES + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic          HS_ON  = (H_POL != 0);
    localparam logic          VS_ON  = (V_POL != 0);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          line;
        logic          frame;
        logic [CW-1:0] sx;
        logic [CW-1:0] sy;
    } pix_t;

    state_t        state, state_nxt;
    logic [CW-1:0] hx, vy;
    logic          h_end, v_end, running;
    pix_t          pix_idle, pix_nxt, pix_q;
    logic          busy_q;

    assign h_end   = (hx == H_LAST);
    assign v_end   = (vy == V_LAST);
    assign running = (state != IDLE);

    // Stopping is only honoured on the last pixel of a frame; a restart request wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_en) state_nxt = RUN;
            RUN:     if (!i_en) state_nxt = DRAIN;
            DRAIN: begin
                if (i_en)                state_nxt = RUN;
                else if (h_end && v_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Counters rest at the origin in IDLE, so every RUN entry starts a fresh frame.
    always_ff @(posedge i_clk) begin
        if (i_rst || !running) begin
            hx <= '0;
            vy <= '0;
        end else if (h_end) begin
            hx <= '0;
            vy <= v_end ? '0 : vy + 1'b1;
        end else begin
            hx <= hx + 1'b1;
        end
    end

    always_comb begin
        pix_idle       = '0;
        pix_idle.hs    = ~HS_ON;
        pix_idle.vs    = ~VS_ON;
        pix_nxt        = pix_idle;
        if (running) begin
            pix_nxt.de    = (32'(hx) < H_RES) && (32'(vy) < V_RES);
            pix_nxt.hs    = ((32'(hx) >= HS_START) && (32'(hx) < HS_END)) ? HS_ON : ~HS_ON;
            pix_nxt.vs    = ((32'(vy) >= VS_START) && (32'(vy) < VS_END)) ? VS_ON : ~VS_ON;
            pix_nxt.line  = (hx == '0);
            pix_nxt.frame = (hx == '0) && (vy == '0);
            pix_nxt.sx    = hx;
            pix_nxt.sy    = vy;
        end
    end

    // Single output stage keeps every strobe aligned with the coordinates it describes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_q  <= pix_idle;
            busy_q <= 1'b0;
        end else begin
            pix_q  <= pix_nxt;
            busy_q <= (state_nxt != IDLE);
        end
    end

    assign o_busy     = busy_q;
    assign o_de       = pix_q.de;
    assign o_hsync    = pix_q.hs;
    assign o_vsync    = pix_q.vs;
    assign o_ctrl_ch0 = {pix_q.vs, pix_q.hs};
    assign o_sx       = pix_q.sx;
    assign o_sy       = pix_q.sy;
    assign o_line     = pix_q.line;
    assign o_frame    = pix_q.frame;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Directed bench: default 640x480 timing on the first lines, plus a 7x6 small-grid
// instance for frame period, stop/restart, mid-frame reset and coincident restart.
module tb_dvi_timing_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_d, en_d, busy_d, de_d, hs_d, vs_d, line_d, frame_d;
    logic [1:0]  ctrl_d;
    logic [11:0] sx_d, sy_d;
    logic        rst_s, en_s, busy_s, de_s, hs_s, vs_s, line_s, frame_s;
    logic [1:0]  ctrl_s;
    logic [3:0]  sx_s, sy_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [30:0] obs_d;
    logic [14:0] obs_s;
    assign obs_d = {sx_d, sy_d, de_d, hs_d, vs_d, ctrl_d, line_d, frame_d};
    assign obs_s = {sx_s, sy_s, de_s, hs_s, vs_s, ctrl_s, line_s, frame_s};

    dvi_timing_ctrl u_dflt (
        .i_clk(clk), .i_rst(rst_d), .i_en(en_d), .o_busy(busy_d), .o_de(de_d),
        .o_hsync(hs_d), .o_vsync(vs_d), .o_ctrl_ch0(ctrl_d), .o_sx(sx_d), .o_sy(sy_d),
        .o_line(line_d), .o_frame(frame_d)
    );

    dvi_timing_ctrl #(
        .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .CW(4)
    ) u_small (
        .i_clk(clk), .i_rst(rst_s), .i_en(en_s), .o_busy(busy_s), .o_de(de_s),
        .o_hsync(hs_s), .o_vsync(vs_s), .o_ctrl_ch0(ctrl_s), .o_sx(sx_s), .o_sy(sy_s),
        .o_line(line_s), .o_frame(frame_s)
    );

    // Expected default-timing outputs k cycles after the (0,0) output.
    function automatic logic [30:0] exp_dflt(int k);
        int x, y;
        logic de, hs, vs;
        x  = k % 800;
        y  = k / 800;
        de = (x < 640) && (y < 480);
        hs = !((x >= 656) && (x < 752));
        vs = !((y >= 490) && (y < 492));
        return {12'(x), 12'(y), de, hs, vs, vs, hs, (x == 0), (x == 0) && (y == 0)};
    endfunction

    // Expected small-grid outputs (7x6, active-high syncs) k cycles after (0,0).
    function automatic logic [14:0] exp_small(int k);
        int x, y;
        logic de, hs, vs;
        x  = k % 7;
        y  = (k / 7) % 6;
        de = (x < 4) && (y < 3);
        hs = (x == 5);
        vs = (y == 4);
        return {4'(x), 4'(y), de, hs, vs, vs, hs, (x == 0), (x == 0) && (y == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_small();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (frame_s === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sync_small: got no o_frame within 100 cycles, required one");
        end
    endtask

    task automatic test_reset();
        logic [31:0] blank_d;
        blank_d = {1'b0, 24'd0, 7'b0111100};
        rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b1; en_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({busy_d, obs_d} !== blank_d) begin
                n_fail++;
                $display("FAIL reset_dflt cyc=%0d: got %h required %h", i, {busy_d, obs_d}, blank_d);
            end
            n_checks++;
            if ({busy_s, obs_s} !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_small cyc=%0d: got %h required 0", i, {busy_s, obs_s});
            end
        end
        rst_d = 1'b0; rst_s = 1'b0;
        tick();
        n_checks++;
        if ({busy_d, obs_d} !== {1'b1, blank_d[30:0]}) begin
            n_fail++;
            $display("FAIL start_edge_n: got %h required %h", {busy_d, obs_d}, {1'b1, blank_d[30:0]});
        end
        tick();
        n_checks++;
        if ({busy_d, obs_d} !== {1'b1, exp_dflt(0)}) begin
            n_fail++;
            $display("FAIL start_dflt_origin: got %h required %h", {busy_d, obs_d}, {1'b1, exp_dflt(0)});
        end
        n_checks++;
        if ({busy_s, obs_s} !== {1'b1, exp_small(0)}) begin
            n_fail++;
            $display("FAIL start_small_origin: got %h required %h", {busy_s, obs_s}, {1'b1, exp_small(0)});
        end
    endtask

    // Starts on the (0,0) sample left by test_reset; covers three full lines.
    task automatic test_default_lines();
        int de_cnt, hs_low, line_cnt;
        de_cnt = 0; hs_low = 0; line_cnt = 0;
        for (int k = 0; k < 2400; k++) begin
            n_checks++;
            if ({busy_d, obs_d} !== {1'b1, exp_dflt(k)}) begin
                n_fail++;
                $display("FAIL dflt_pixel k=%0d: got %h required %h", k, {busy_d, obs_d}, {1'b1, exp_dflt(k)});
            end
            de_cnt   += int'(de_d);
            hs_low   += int'(!hs_d);
            line_cnt += int'(line_d);
            tick();
        end
        n_checks++;
        if (de_cnt !== 1920) begin
            n_fail++;
            $display("FAIL dflt_de_count: got %0d required 1920", de_cnt);
        end
        n_checks++;
        if (hs_low !== 288) begin
            n_fail++;
            $display("FAIL dflt_hsync_count: got %0d required 288", hs_low);
        end
        n_checks++;
        if (line_cnt !== 3) begin
            n_fail++;
            $display("FAIL dflt_line_count: got %0d required 3", line_cnt);
        end
    endtask

    task automatic test_small_frame();
        int de_cnt, hs_cnt, vs_cnt;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        sync_small();
        for (int k = 0; k <= 42; k++) begin
            n_checks++;
            if ({busy_s, obs_s} !== {1'b1, exp_small(k)}) begin
                n_fail++;
                $display("FAIL small_pixel k=%0d: got %h required %h", k, {busy_s, obs_s}, {1'b1, exp_small(k)});
            end
            if (k < 42) begin
                de_cnt += int'(de_s);
                hs_cnt += int'(hs_s);
                vs_cnt += int'(vs_s);
                tick();
            end
        end
        n_checks++;
        if ({de_cnt, hs_cnt, vs_cnt} !== {32'd12, 32'd6, 32'd7}) begin
            n_fail++;
            $display("FAIL small_counts: got de=%0d hs=%0d vs=%0d required 12 6 7", de_cnt, hs_cnt, vs_cnt);
        end
    endtask

    task automatic test_stop_restart();
        logic [15:0] e;
        sync_small();
        for (int k = 0; k < 45; k++) begin
            e = (k < 42) ? {(k < 41), exp_small(k)} : 16'd0;
            n_checks++;
            if ({busy_s, obs_s} !== e) begin
                n_fail++;
                $display("FAIL stop k=%0d: got %h required %h", k, {busy_s, obs_s}, e);
            end
            if (k == 14) en_s = 1'b0;
            tick();
        end
        en_s = 1'b1;
        tick();
        n_checks++;
        if ({busy_s, obs_s} !== 16'h8000) begin
            n_fail++;
            $display("FAIL restart_edge_n: got %h required 8000", {busy_s, obs_s});
        end
        tick();
        for (int k = 0; k <= 42; k++) begin
            n_checks++;
            if ({busy_s, obs_s} !== {1'b1, exp_small(k)}) begin
                n_fail++;
                $display("FAIL drain_restart k=%0d: got %h required %h", k, {busy_s, obs_s}, {1'b1, exp_small(k)});
            end
            if (k == 14) en_s = 1'b0;
            if (k == 28) en_s = 1'b1;
            if (k < 42) tick();
        end
    endtask

    task automatic test_reset_mid();
        sync_small();
        for (int k = 0; k <= 9; k++) begin
            n_checks++;
            if ({busy_s, obs_s} !== {1'b1, exp_small(k)}) begin
                n_fail++;
                $display("FAIL pre_reset k=%0d: got %h required %h", k, {busy_s, obs_s}, {1'b1, exp_small(k)});
            end
            if (k < 9) tick();
        end
        rst_s = 1'b1;
        tick();
        n_checks++;
        if ({busy_s, obs_s} !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h required 0", {busy_s, obs_s});
        end
        rst_s = 1'b0;
        tick();
        n_checks++;
        if ({busy_s, obs_s} !== 16'h8000) begin
            n_fail++;
            $display("FAIL post_reset_n: got %h required 8000", {busy_s, obs_s});
        end
        tick();
        n_checks++;
        if ({busy_s, obs_s} !== {1'b1, exp_small(0)}) begin
            n_fail++;
            $display("FAIL post_reset_origin: got %h required %h", {busy_s, obs_s}, {1'b1, exp_small(0)});
        end
    endtask

    task automatic test_back_to_back();
        sync_small();
        for (int k = 0; k <= 45; k++) begin
            n_checks++;
            if ({busy_s, obs_s} !== {1'b1, exp_small(k)}) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d: got %h required %h", k, {busy_s, obs_s}, {1'b1, exp_small(k)});
            end
            if (k == 14) en_s = 1'b0;
            if (k == 40) en_s = 1'b1;
            tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_lines();
        test_small_frame();
        test_stop_restart();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
